// File: rtl/uart_word24_pkg.sv
// uart_word24_pkg: shared state encodings and bit-timing helper for the
// uart_word24_link block.
`timescale 1ns/1ps

package uart_word24_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_HOLD
  } rx_state_t;

  localparam int BYTES_PER_WORD = 3;

  // Clock cycles per serial bit; integer division truncates.
  function automatic int clks_per_bit(input int clock_rate, input int baud_rate);
    return clock_rate / baud_rate;
  endfunction

endpackage

// File: rtl/uart_word24_link_packer.sv
// byte_packer_24: collects received bytes three at a time (first byte most
// significant) into a 24-bit word offered downstream with valid/ready.
`timescale 1ns/1ps

module byte_packer_24
  import uart_word24_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  input  logic        word_ready,
  output logic [23:0] word,
  output logic        word_valid
);

  localparam logic [1:0] LAST_SLOT = 2'(BYTES_PER_WORD - 1);

  // Only the two most recent bytes are ever needed to build a word, so the
  // shift register keeps 16 bits.
  logic [15:0] shreg;
  logic [1:0]  count;
  logic [23:0] word_q;
  logic        word_valid_q;
  logic        word_free;
  logic        take;
  logic        complete;

  // The word slot counts as free when it is empty or being consumed this cycle,
  // which lets a completing byte replace the old word without a bubble.
  assign word_free  = !word_valid_q || word_ready;
  assign byte_ready = (count != LAST_SLOT) || word_free;
  assign take       = byte_valid && byte_ready;
  assign complete   = take && (count == LAST_SLOT);

  assign word       = word_q;
  assign word_valid = word_valid_q;

  // Shift in accepted bytes, publish every third one, clear valid on handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg        <= '0;
      count        <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else if (enable) begin
      if (take) begin
        shreg <= {shreg[7:0], byte_data};
        count <= (count == LAST_SLOT) ? 2'd0 : count + 2'd1;
      end
      if (complete) begin
        word_q       <= {shreg, byte_data};
        word_valid_q <= 1'b1;
      end else if (word_valid_q && word_ready) begin
        word_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_word24_link.sv
// uart_word24_link: full-duplex 8N1 UART; received bytes are packed into
// 24-bit words by byte_packer_24, transmit accepts single bytes.
// Optional feature macro: UART_FRAMING_CHECK_EN (drop frames whose stop bit
// samples low and pulse frame_err).
//
// TX state | meaning
// TX_IDLE  | line high, tx_ready high, waiting for tx_valid
// TX_START | driving the start bit (low)
// TX_DATA  | driving data bits LSB first
// TX_STOP  | driving the stop bit (high)
//
// RX state | meaning
// RX_IDLE  | waiting for a low on the synchronized line
// RX_START | counting to mid start bit to reject glitches
// RX_DATA  | sampling 8 data bits at bit centres
// RX_STOP  | waiting for the stop bit sample
// RX_HOLD  | byte offered to the packer, line ignored
`timescale 1ns/1ps

module uart_word24_link
  import uart_word24_pkg::*;
#(
  parameter int CLOCK_RATE = 10000,
  parameter int BAUD_RATE  = 300
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        tx_valid,
  input  logic [7:0]  tx_data,
  output logic        tx_ready,
  output logic        txd,
  input  logic        rxd,
  input  logic        word_ready,
  output logic [23:0] word,
  output logic        word_valid,
  output logic        frame_err
);

  localparam int CPB = clks_per_bit(CLOCK_RATE, BAUD_RATE);
  localparam int TW  = $clog2(CPB);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CPB - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CPB / 2 - 1);

  if (CPB < 4) begin : g_cpb_check
    $error("uart_word24_link: CLOCK_RATE/BAUD_RATE must be at least 4");
  end

  // ---------------- transmitter ----------------
  tx_state_t      tx_state, tx_state_next;
  logic [TW-1:0]  tx_timer, tx_timer_next;
  logic [7:0]     tx_shift, tx_shift_next;
  logic [2:0]     tx_bit, tx_bit_next;
  logic           txd_q, txd_next;

  assign tx_ready = (tx_state == TX_IDLE);
  assign txd      = txd_q;

  // TX state, bit timer and registered line output.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_timer <= '0;
      tx_shift <= '0;
      tx_bit   <= '0;
      txd_q    <= 1'b1;
    end else if (enable) begin
      tx_state <= tx_state_next;
      tx_timer <= tx_timer_next;
      tx_shift <= tx_shift_next;
      tx_bit   <= tx_bit_next;
      txd_q    <= txd_next;
    end
  end

  // TX next state: each bit runs a down-counter from CPB-1 to terminal zero.
  always_comb begin
    tx_state_next = tx_state;
    tx_timer_next = tx_timer;
    tx_shift_next = tx_shift;
    tx_bit_next   = tx_bit;
    txd_next      = txd_q;
    unique case (tx_state)
      TX_IDLE: begin
        txd_next = 1'b1;
        if (tx_valid) begin
          tx_state_next = TX_START;
          tx_timer_next = BIT_LAST;
          tx_shift_next = tx_data;
          txd_next      = 1'b0;
        end
      end
      TX_START: begin
        if (tx_timer == '0) begin
          tx_state_next = TX_DATA;
          tx_timer_next = BIT_LAST;
          tx_bit_next   = '0;
          txd_next      = tx_shift[0];
        end else begin
          tx_timer_next = tx_timer - 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_timer == '0) begin
          tx_timer_next = BIT_LAST;
          if (tx_bit == 3'd7) begin
            tx_state_next = TX_STOP;
            txd_next      = 1'b1;
          end else begin
            tx_bit_next   = tx_bit + 3'd1;
            tx_shift_next = {1'b0, tx_shift[7:1]};
            txd_next      = tx_shift[1];
          end
        end else begin
          tx_timer_next = tx_timer - 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_timer == '0) begin
          tx_state_next = TX_IDLE;
          txd_next      = 1'b1;
        end else begin
          tx_timer_next = tx_timer - 1'b1;
        end
      end
      default: begin
        tx_state_next = TX_IDLE;
        txd_next      = 1'b1;
      end
    endcase
  end

  // ---------------- receiver ----------------
  logic           rxd_meta, rxd_sync;
  rx_state_t      rx_state, rx_state_next;
  logic [TW-1:0]  rx_timer, rx_timer_next;
  logic [7:0]     rx_shift, rx_shift_next;
  logic [2:0]     rx_bit, rx_bit_next;
  logic           byte_valid;
  logic           byte_ready;

  // Two-flop synchronizer on the asynchronous pin; idles high.
  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
    end
  end

`ifdef UART_FRAMING_CHECK_EN
  logic frame_err_q, frame_err_next;
  assign frame_err = frame_err_q;
`else
  assign frame_err = 1'b0;
`endif

  // RX state, sample timer and data shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state    <= RX_IDLE;
      rx_timer    <= '0;
      rx_shift    <= '0;
      rx_bit      <= '0;
`ifdef UART_FRAMING_CHECK_EN
      frame_err_q <= 1'b0;
`endif
    end else if (enable) begin
      rx_state    <= rx_state_next;
      rx_timer    <= rx_timer_next;
      rx_shift    <= rx_shift_next;
      rx_bit      <= rx_bit_next;
`ifdef UART_FRAMING_CHECK_EN
      frame_err_q <= frame_err_next;
`endif
    end
  end

  // RX next state: half-bit recheck of the start bit, then centre sampling.
  always_comb begin
    rx_state_next = rx_state;
    rx_timer_next = rx_timer;
    rx_shift_next = rx_shift;
    rx_bit_next   = rx_bit;
`ifdef UART_FRAMING_CHECK_EN
    frame_err_next = 1'b0;
`endif
    unique case (rx_state)
      RX_IDLE: begin
        if (!rxd_sync) begin
          rx_state_next = RX_START;
          rx_timer_next = HALF_LAST;
        end
      end
      RX_START: begin
        if (rx_timer == '0) begin
          if (!rxd_sync) begin
            rx_state_next = RX_DATA;
            rx_timer_next = BIT_LAST;
            rx_bit_next   = '0;
          end else begin
            rx_state_next = RX_IDLE;
          end
        end else begin
          rx_timer_next = rx_timer - 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_timer == '0) begin
          rx_shift_next = {rxd_sync, rx_shift[7:1]};
          rx_timer_next = BIT_LAST;
          if (rx_bit == 3'd7) begin
            rx_state_next = RX_STOP;
          end else begin
            rx_bit_next = rx_bit + 3'd1;
          end
        end else begin
          rx_timer_next = rx_timer - 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_timer == '0) begin
`ifdef UART_FRAMING_CHECK_EN
          if (!rxd_sync) begin
            rx_state_next  = RX_IDLE;
            frame_err_next = 1'b1;
          end else begin
            rx_state_next = RX_HOLD;
          end
`else
          rx_state_next = RX_HOLD;
`endif
        end else begin
          rx_timer_next = rx_timer - 1'b1;
        end
      end
      RX_HOLD: begin
        if (byte_ready) begin
          rx_state_next = RX_IDLE;
        end
      end
      default: begin
        rx_state_next = RX_IDLE;
      end
    endcase
  end

  assign byte_valid = (rx_state == RX_HOLD);

  byte_packer_24 u_packer (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .byte_valid (byte_valid),
    .byte_data  (rx_shift),
    .byte_ready (byte_ready),
    .word_ready (word_ready),
    .word       (word),
    .word_valid (word_valid)
  );

endmodule

// File: tb/tb_uart_word24_link.sv
// tb_uart_word24_link: self-checking bench for uart_word24_link.
`timescale 1ns/1ps

module tb_uart_word24_link;

  localparam int CPB = 10000 / 300;

  logic        clk = 1'b0;
  logic        reset, enable, tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready, txd, rxd, word_ready;
  logic [23:0] word;
  logic        word_valid, frame_err;

  logic loopback, rxd_drv, wr_man, wr_rnd, rand_mode;
  assign rxd        = loopback ? txd : rxd_drv;
  assign word_ready = rand_mode ? wr_rnd : wr_man;

  always #5 clk = ~clk;

  uart_word24_link dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .txd        (txd),
    .rxd        (rxd),
    .word_ready (word_ready),
    .word       (word),
    .word_valid (word_valid),
    .frame_err  (frame_err)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [23:0] got[$];
  int          vcycles = 0;
  int          ferr_cycles = 0;

  // Record handshaken words and count valid / frame_err cycles.
  always @(negedge clk) begin
    if (word_valid && word_ready) got.push_back(word);
    if (word_valid) vcycles++;
    if (frame_err) ferr_cycles++;
  end

  always @(posedge clk) begin
    #1 wr_rnd = 1'($urandom_range(0, 1));
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_tx_idle();
    int t;
    t = 0;
    while (!tx_ready && t < 2000) begin
      cyc(1);
      t++;
    end
    if (!tx_ready) check("tx_ready_timeout", 32'(tx_ready), 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    wait_tx_idle();
    tx_valid = 1'b1;
    tx_data  = b;
    cyc(1);
    tx_valid = 1'b0;
  endtask

  task automatic wait_words(input int target, input int budget, input string name);
    int t;
    t = 0;
    while (got.size() < target && t < budget) begin
      cyc(1);
      t++;
    end
    check({name, "_arrived"}, 32'(got.size() >= target), 32'd1);
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop_val, input int stop_len);
    rxd_drv = 1'b0;
    cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = b[i];
      cyc(CPB);
    end
    rxd_drv = stop_val;
    cyc(stop_len);
    rxd_drv = 1'b1;
    cyc(2 * CPB);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
  endtask

  typedef struct packed {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [23:0] w;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int          base, v0, f0, rdy_low;
    int          bad[10];
    logic [9:0]  frame;
    logic [7:0]  rbytes[9];
    logic [23:0] exp_w;
    logic        t0;

    vecs[0] = '{8'hAA, 8'h01, 8'hAA, 24'hAA01AA};
    vecs[1] = '{8'h00, 8'hFF, 8'h00, 24'h00FF00};
    vecs[2] = '{8'h12, 8'h34, 8'h56, 24'h123456};
    vecs[3] = '{8'hFF, 8'h80, 8'h7F, 24'hFF807F};

    reset = 1'b1; enable = 1'b1; tx_valid = 1'b0; tx_data = '0;
    loopback = 1'b0; rxd_drv = 1'b1; wr_man = 1'b1; rand_mode = 1'b0;
    cyc(3);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_word", 32'(word), 32'd0);
    check("rst_word_valid", 32'(word_valid), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    reset = 1'b0;
    cyc(2);

    // TX waveform for 0x01 with the receiver isolated.
    frame = {1'b1, 8'h01, 1'b0};
    for (int k = 0; k < 10; k++) bad[k] = 0;
    rdy_low = 0;
    tx_valid = 1'b1; tx_data = 8'h01;
    cyc(1);
    tx_valid = 1'b0;
    for (int c = 0; c < 10 * CPB; c++) begin
      if (txd !== frame[c / CPB]) bad[c / CPB]++;
      if (tx_ready === 1'b0) rdy_low++;
      cyc(1);
    end
    for (int k = 0; k < 10; k++) check($sformatf("tx_wave_bit%0d_bad_cycles", k), 32'(bad[k]), 32'd0);
    check("tx_ready_low_cycles", 32'(rdy_low), 32'(10 * CPB));
    check("tx_ready_after_frame", 32'(tx_ready), 32'd1);
    check("txd_idle_after_frame", 32'(txd), 32'd1);

    // Table-driven loopback words with word_ready held high.
    loopback = 1'b1;
    for (int i = 0; i < 4; i++) begin
      base = got.size();
      v0 = vcycles;
      send_byte(vecs[i].b0);
      send_byte(vecs[i].b1);
      send_byte(vecs[i].b2);
      wait_words(base + 1, 2000, $sformatf("vec%0d", i));
      cyc(5);
      check($sformatf("vec%0d_word", i), 32'(got[base]), 32'(vecs[i].w));
      check($sformatf("vec%0d_valid_cycles", i), 32'(vcycles - v0), 32'd1);
    end

    // Backpressure: six bytes with word_ready low.
    wait_tx_idle();
    wr_man = 1'b0;
    base = got.size();
    for (int i = 0; i < 6; i++) send_byte(8'h11 + 8'(i));
    wait_tx_idle();
    cyc(2 * CPB);
    check("bp_word_held", 32'(word), 32'h111213);
    check("bp_valid_held", 32'(word_valid), 32'd1);
    check("bp_no_handshake", 32'(got.size() - base), 32'd0);
    wr_man = 1'b1;
    wait_words(base + 2, 100, "bp");
    check("bp_first", 32'(got[base]), 32'h111213);
    check("bp_second", 32'(got[base + 1]), 32'h141516);
    cyc(3);
    check("bp_valid_cleared", 32'(word_valid), 32'd0);

    // Glitch on the line: no byte, no frame error.
    loopback = 1'b0;
    pulse_reset();
    f0 = ferr_cycles;
    base = got.size();
    rxd_drv = 1'b0;
    cyc(5);
    rxd_drv = 1'b1;
    cyc(3 * CPB);
    check("glitch_frame_err", 32'(ferr_cycles - f0), 32'd0);
    loopback = 1'b1;
    send_byte(8'h21); send_byte(8'h22); send_byte(8'h23);
    wait_words(base + 1, 2000, "glitch");
    check("glitch_word", 32'(got[base]), 32'h212223);

    // Frame with a low stop bit.
    wait_tx_idle();
    cyc(CPB);
    loopback = 1'b0;
    base = got.size();
    f0 = ferr_cycles;
    drive_frame(8'h55, 1'b0, (3 * CPB) / 4);
    loopback = 1'b1;
`ifdef UART_FRAMING_CHECK_EN
    check("ferr_pulse_cycles", 32'(ferr_cycles - f0), 32'd1);
    send_byte(8'hC3); send_byte(8'h3C); send_byte(8'h5A);
    exp_w = 24'hC33C5A;
`else
    check("ferr_tied_low", 32'(ferr_cycles - f0), 32'd0);
    send_byte(8'hC3); send_byte(8'h3C);
    exp_w = 24'h55C33C;
`endif
    wait_words(base + 1, 2000, "ferr");
    check("ferr_word", 32'(got[base]), 32'(exp_w));

    // Reset in the middle of a TX frame.
    wait_tx_idle();
    send_byte(8'h5A);
    cyc(100);
    reset = 1'b1;
    cyc(1);
    check("midtx_rst_txd", 32'(txd), 32'd1);
    check("midtx_rst_tx_ready", 32'(tx_ready), 32'd1);
    reset = 1'b0;
    cyc(2 * CPB);

    // Reset after two received bytes discards them.
    send_byte(8'h01); send_byte(8'h02);
    wait_tx_idle();
    cyc(CPB);
    base = got.size();
    pulse_reset();
    send_byte(8'h31); send_byte(8'h32); send_byte(8'h33);
    wait_words(base + 1, 2000, "rst2");
    check("rst2_fresh_word", 32'(got[base]), 32'h313233);

    // Enable low mid-frame freezes both directions.
    wait_tx_idle();
    base = got.size();
    send_byte(8'h7E);
    cyc(100);
    t0 = txd;
    enable = 1'b0;
    cyc(40);
    check("en_hold_txd", 32'(txd), 32'(t0));
    check("en_hold_tx_ready", 32'(tx_ready), 32'd0);
    enable = 1'b1;
    send_byte(8'h81); send_byte(8'h42);
    wait_words(base + 1, 2000, "en");
    check("en_word", 32'(got[base]), 32'h7E8142);

    // Randomized bytes with random word_ready against a packing model.
    wait_tx_idle();
    cyc(5);
    rand_mode = 1'b1;
    base = got.size();
    for (int i = 0; i < 9; i++) begin
      rbytes[i] = 8'($urandom);
      send_byte(rbytes[i]);
    end
    wait_words(base + 3, 3000, "rand");
    cyc(50);
    for (int k = 0; k < 3; k++) begin
      exp_w = {rbytes[3 * k], rbytes[3 * k + 1], rbytes[3 * k + 2]};
      check($sformatf("rand_word%0d", k), 32'(got[base + k]), 32'(exp_w));
    end
    check("rand_word_count", 32'(got.size() - base), 32'd3);
    rand_mode = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
